// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM duty-cycle fade sequencer.
// The clamp helper keeps every duty value inside the legal PWM window.
package pwm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RAMP = 2'd1,
      JUMP = 2'd2
   } state_t;

   // 10-step PWM: duty 0 and 10 would be a constant level, so keep to 1..9
   localparam int PWM_DUTY_MIN = 1;
   localparam int PWM_DUTY_MAX = 9;
   localparam int PWM_DUTY_RST = 5;

   function automatic int clamp_duty(input int v, input int lo, input int hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

endpackage

// File: rtl/pwm_period_div.sv
// Counts PWM period_end pulses and emits step_tick on every div-th one.
// step_tick is combinational so the caller commits on the same edge.
module pwm_period_div #(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic             period_end,
   input  logic [DIV_W-1:0] div,
   output logic             step_tick
);

   logic [DIV_W-1:0] cnt_p0;
   logic             last;

   assign last      = (cnt_p0 == div - DIV_W'(1));
   assign step_tick = en & period_end & last;

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         cnt_p0 <= '0;
      end else if (en && period_end) begin
         cnt_p0 <= last ? '0 : cnt_p0 + DIV_W'(1);
      end
   end

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Owns one PWM channel's duty register: ramp/jump commands and manual
// inc/dec requests, all committed only on the PWM period boundary.
module pwm_fade_ctrl
   import pwm_pkg::*;
#(
   parameter int DUTY_W   = 4,
   parameter int DUTY_MIN = PWM_DUTY_MIN,
   parameter int DUTY_MAX = PWM_DUTY_MAX,
   parameter int DUTY_RST = PWM_DUTY_RST,
   parameter int DIV_W    = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              period_end,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_mode,
   input  logic [DUTY_W-1:0] cmd_target,
   input  logic [DIV_W-1:0]  cmd_div,
   input  logic              cmd_abort,
   input  logic              inc_pulse,
   input  logic              dec_pulse,
   output logic [DUTY_W-1:0] duty_out,
   output logic              duty_load,
   output logic              busy,
   output logic              done
);

   state_t             state;
   logic [DUTY_W-1:0]  tgt_q;
   logic [DIV_W-1:0]   div_q;
   logic signed [1:0]  pend_q;

   logic [DUTY_W-1:0]  tgt_clamp;
   logic [DUTY_W-1:0]  man_duty;
   logic [DUTY_W-1:0]  ramp_duty;
   logic [DIV_W-1:0]   div_in;
   logic               accept;
   logic               step_tick;

   assign cmd_ready = (state == IDLE);
   assign busy      = (state == RAMP) || (state == JUMP);
   assign accept    = cmd_valid && cmd_ready;

   always_comb begin
      tgt_clamp = DUTY_W'(clamp_duty(int'(cmd_target), DUTY_MIN, DUTY_MAX));
      man_duty  = DUTY_W'(clamp_duty(int'(duty_out) + int'(pend_q), DUTY_MIN, DUTY_MAX));
      ramp_duty = (tgt_q > duty_out) ? duty_out + DUTY_W'(1) : duty_out - DUTY_W'(1);
      div_in    = (cmd_div == '0) ? DIV_W'(1) : cmd_div;
   end

   pwm_period_div #(
      .DIV_W(DIV_W)
   ) u_div (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (state == RAMP),
      .clr       (accept),
      .period_end(period_end),
      .div       (div_q),
      .step_tick (step_tick)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         duty_out  <= DUTY_W'(DUTY_RST);
         duty_load <= 1'b0;
         done      <= 1'b0;
         pend_q    <= 2'sd0;
      end else begin
         duty_load <= 1'b0;
         done      <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  tgt_q  <= tgt_clamp;
                  div_q  <= div_in;
                  pend_q <= 2'sd0;
                  if (tgt_clamp == duty_out) done <= 1'b1;
                  else state <= cmd_mode ? JUMP : RAMP;
               end else begin
                  if (period_end && pend_q != 2'sd0) begin
                     if (man_duty != duty_out) begin
                        duty_out  <= man_duty;
                        duty_load <= 1'b1;
                     end
                     pend_q <= 2'sd0;
                  end
                  // A pulse arriving with the commit edge becomes the next request
                  if (inc_pulse)      pend_q <= 2'sd1;
                  else if (dec_pulse) pend_q <= -2'sd1;
               end
            end
            RAMP: begin
               if (cmd_abort) begin
                  state <= IDLE;
               end else if (step_tick) begin
                  duty_out  <= ramp_duty;
                  duty_load <= 1'b1;
                  if (ramp_duty == tgt_q) begin
                     done  <= 1'b1;
                     state <= IDLE;
                  end
               end
            end
            JUMP: begin
               if (cmd_abort) begin
                  state <= IDLE;
               end else if (period_end) begin
                  duty_out  <= tgt_q;
                  duty_load <= 1'b1;
                  done      <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Directed bench for pwm_fade_ctrl: a per-cycle vector table plus
// hand-written ramp, abort and mid-ramp reset sequences.
module tb_pwm_fade_ctrl;

   logic       clk;
   logic       rst_n;
   logic       period_end;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_mode;
   logic [3:0] cmd_target;
   logic [7:0] cmd_div;
   logic       cmd_abort;
   logic       inc_pulse;
   logic       dec_pulse;
   logic [3:0] duty_out;
   logic       duty_load;
   logic       busy;
   logic       done;

   int n_tests;
   int n_fail;

   pwm_fade_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .period_end(period_end),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_mode  (cmd_mode),
      .cmd_target(cmd_target),
      .cmd_div   (cmd_div),
      .cmd_abort (cmd_abort),
      .inc_pulse (inc_pulse),
      .dec_pulse (dec_pulse),
      .duty_out  (duty_out),
      .duty_load (duty_load),
      .busy      (busy),
      .done      (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic       rst_n;
      logic       pe;
      logic       cv;
      logic       mode;
      logic [3:0] tgt;
      logic [7:0] div;
      logic       abort;
      logic       inc;
      logic       dec;
      logic [3:0] e_duty;
      logic       e_load;
      logic       e_busy;
      logic       e_done;
      logic       e_ready;
   } vec_t;

   localparam int NV = 25;
   vec_t vecs [NV];

   task automatic drive(input logic r, input logic pe, input logic cv, input logic mode,
                        input logic [3:0] tgt, input logic [7:0] div, input logic abort,
                        input logic inc, input logic dec);
      rst_n      = r;
      period_end = pe;
      cmd_valid  = cv;
      cmd_mode   = mode;
      cmd_target = tgt;
      cmd_div    = div;
      cmd_abort  = abort;
      inc_pulse  = inc;
      dec_pulse  = dec;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycle(input logic pe);
      drive(1'b1, pe, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic check(input string name, input int actual, input int expected);
      n_tests++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Outputs packed as {duty[3:0], load, busy, done, ready}
   function automatic int pack_out(input logic [3:0] d, input logic l, input logic b,
                                   input logic dn, input logic r);
      return int'({d, l, b, dn, r});
   endfunction

   initial begin
      int nloads;
      int ndone;
      n_tests = 0;
      n_fail  = 0;

      //           rst  pe  cv  md  tgt    div   ab  inc dec | duty ld bs dn rd
      vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,4'd0, 8'd0,1'b0,1'b0,1'b0, 4'd5,1'b0,1'b0,1'b0,1'b1};
      vecs[1]  = '{1'b0,1'b0,1'b0,1'b0,4'd0, 8'd0,1'b0,1'b0,1'b0, 4'd5,1'b0,1'b0,1'b0,1'b1};
      vecs[2]  = '{1'b1,1'b0,1'b0,1'b0,4'd0, 8'd0,1'b0,1'b0,1'b0, 4'd5,1'b0,1'b0,1'b0,1'b1};
      vecs[3]  = '{1'b1,1'b0,1'b1,1'b1,4'd15,8'd0,1'b0,1'b0,1'b0, 4'd5,1'b0,1'b1,1'b0,1'b0};
      vecs[4]  = '{1'b1,1'b0,1'b0,1'b0,4'd0, 8'd0,1'b0,1'b0,1'b0, 4'd5,1'b0,1'b1,1'b0,1'b0};
      vecs[5]  = '{1'b1,1'b1,1'b0,1'b0,4'd0, 8'd0,1'b0,1'b0,1'b0, 4'd9,1'b1,1'b0,1'b1,1'b1};
      vecs[6]  = '{1'b1,1'b0,1'b0,1'b0,4'd0, 8'd0,1'b0,1'b0,1'b0, 4'd9,1'b0,1'b0,1'b0,1'b1};
      vecs[7]  = '{1'b1,1'b0,1'b0,1'b0,4'd0, 8'd0,1'b0,1'b1,1'b0, 4'd9,1'b0,1'b0,1'b0,1'b1};
      vecs[8]  = '{1'b1,1'b1,1'b0,1'b0,4'd0, 8'd0,1'b0,1'b0,1'b0, 4'd9,1'b0,1'b0,1'b0,1'b1};
      vecs[9]  = '{1'b1,1'b0,1'b0,1'b0,4'd0, 8'd0,1'b0,1'b0,1'b1, 4'd9,1'b0,1'b0,1'b0,1'b1};
      vecs[10] = '{1'b1,1'b0,1'b0,1'b0,4'd0, 8'd0,1'b0,1'b1,1'b1, 4'd9,1'b0,1'b0,1'b0,1'b1};
      vecs[11] = '{1'b1,1'b1,1'b0,1'b0,4'd0, 8'd0,1'b0,1'b0,1'b0, 4'd9,1'b0,1'b0,1'b0,1'b1};
      vecs[12] = '{1'b1,1'b0,1'b0,1'b0,4'd0, 8'd0,1'b0,1'b0,1'b1, 4'd9,1'b0,1'b0,1'b0,1'b1};
      vecs[13] = '{1'b1,1'b1,1'b0,1'b0,4'd0, 8'd0,1'b0,1'b0,1'b0, 4'd8,1'b1,1'b0,1'b0,1'b1};
      vecs[14] = '{1'b1,1'b0,1'b0,1'b0,4'd0, 8'd0,1'b0,1'b0,1'b0, 4'd8,1'b0,1'b0,1'b0,1'b1};
      vecs[15] = '{1'b1,1'b0,1'b1,1'b0,4'd8, 8'd3,1'b0,1'b0,1'b0, 4'd8,1'b0,1'b0,1'b1,1'b1};
      vecs[16] = '{1'b1,1'b0,1'b0,1'b0,4'd0, 8'd0,1'b0,1'b0,1'b0, 4'd8,1'b0,1'b0,1'b0,1'b1};
      vecs[17] = '{1'b1,1'b0,1'b0,1'b0,4'd0, 8'd0,1'b0,1'b1,1'b0, 4'd8,1'b0,1'b0,1'b0,1'b1};
      vecs[18] = '{1'b1,1'b1,1'b0,1'b0,4'd0, 8'd0,1'b0,1'b0,1'b0, 4'd9,1'b1,1'b0,1'b0,1'b1};
      vecs[19] = '{1'b1,1'b0,1'b1,1'b0,4'd0, 8'd1,1'b0,1'b1,1'b0, 4'd9,1'b0,1'b1,1'b0,1'b0};
      vecs[20] = '{1'b1,1'b0,1'b0,1'b0,4'd0, 8'd0,1'b0,1'b1,1'b0, 4'd9,1'b0,1'b1,1'b0,1'b0};
      vecs[21] = '{1'b1,1'b1,1'b0,1'b0,4'd0, 8'd0,1'b0,1'b0,1'b0, 4'd8,1'b1,1'b1,1'b0,1'b0};
      vecs[22] = '{1'b1,1'b1,1'b0,1'b0,4'd0, 8'd0,1'b1,1'b0,1'b0, 4'd8,1'b0,1'b0,1'b0,1'b1};
      vecs[23] = '{1'b1,1'b1,1'b0,1'b0,4'd0, 8'd0,1'b0,1'b0,1'b0, 4'd8,1'b0,1'b0,1'b0,1'b1};
      vecs[24] = '{1'b1,1'b0,1'b0,1'b0,4'd0, 8'd0,1'b1,1'b0,1'b0, 4'd8,1'b0,1'b0,1'b0,1'b1};

      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].rst_n, vecs[i].pe, vecs[i].cv, vecs[i].mode, vecs[i].tgt,
               vecs[i].div, vecs[i].abort, vecs[i].inc, vecs[i].dec);
         check($sformatf("vec%0d {duty,ld,busy,done,rdy}", i),
               pack_out(duty_out, duty_load, busy, done, cmd_ready),
               pack_out(vecs[i].e_duty, vecs[i].e_load, vecs[i].e_busy,
                        vecs[i].e_done, vecs[i].e_ready));
      end

      // Ramp 5 -> 8, div 2, period_end every 10 cycles
      drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd8, 8'd2, 1'b0, 1'b0, 1'b0);
      check("ramp_busy_after_accept", int'(busy), 1);
      nloads = 0;
      ndone  = 0;
      for (int c = 0; c < 70; c++) begin
         idle_cycle(c % 10 == 9);
         if (duty_load) begin
            nloads++;
            check($sformatf("ramp_step%0d_duty", nloads), int'(duty_out), 5 + nloads);
         end
         if (done) begin
            ndone++;
            check("ramp_done_with_load8", int'({duty_out, duty_load}), int'({4'd8, 1'b1}));
         end
         if (c == 30) check("ramp_busy_mid", int'(busy), 1);
      end
      check("ramp_load_count", nloads, 3);
      check("ramp_done_count", ndone, 1);
      check("ramp_busy_end", int'({busy, cmd_ready}), int'(2'b01));

      // Abort: ramp 5 -> 1 with div 1, abort after first step
      drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 8'd1, 1'b0, 1'b0, 1'b0);
      idle_cycle(1'b1);
      check("abort_first_step", int'({duty_out, duty_load}), int'({4'd4, 1'b1}));
      drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 1'b0, 1'b0);
      check("abort_state", pack_out(duty_out, duty_load, busy, done, cmd_ready),
            pack_out(4'd4, 1'b0, 1'b0, 1'b0, 1'b1));
      ndone  = 0;
      nloads = 0;
      for (int c = 0; c < 20; c++) begin
         idle_cycle(c % 5 == 4);
         if (done) ndone++;
         if (duty_load) nloads++;
      end
      check("abort_no_done", ndone, 0);
      check("abort_no_load", nloads, 0);
      check("abort_duty_hold", int'(duty_out), 4);

      // Mid-ramp reset, then a same-duty command
      drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd9, 8'd1, 1'b0, 1'b0, 1'b0);
      idle_cycle(1'b1);
      check("midrst_step", int'(duty_out), 5);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0);
      check("midrst_reset", pack_out(duty_out, duty_load, busy, done, cmd_ready),
            pack_out(4'd5, 1'b0, 1'b0, 1'b0, 1'b1));
      drive(1'b1, 1'b0, 1'b1, 1'b0, 4'd5, 8'd1, 1'b0, 1'b0, 1'b0);
      check("midrst_same_done", pack_out(duty_out, duty_load, busy, done, cmd_ready),
            pack_out(4'd5, 1'b0, 1'b0, 1'b1, 1'b1));
      idle_cycle(1'b0);
      check("midrst_done_pulse", int'(done), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pwm_fade_ctrl.md
Name: pwm_fade_ctrl

Overview:
- Sequencer that owns the duty-cycle register of one PWM channel.
- Accepts commands: either ramp to a target duty one step at a time, or jump straight to it. Also accepts debounced manual inc/dec pulses.
- Every duty update is committed only on the PWM period boundary, so the output never glitches.
- Sits between the button-debounce/command logic and the 10-step PWM counter datapath.

Parameters:
- DUTY_W, 4, width of duty value and target.
- DUTY_MIN, 1, lowest permitted duty.
- DUTY_MAX, 9, highest permitted duty (PERIOD-1 for a 10-step PWM).
- DUTY_RST, 5, duty value after reset (50%).
- DIV_W, 8, width of the ramp step divider.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, synchronous active-low reset.
- period_end, in, 1, one-cycle pulse from the PWM counter on the wrap to 0.
- cmd_valid, in, 1, command request.
- cmd_ready, out, 1, high only in IDLE; a command is accepted on cmd_valid & cmd_ready.
- cmd_mode, in, 1, 0 = ramp, 1 = jump.
- cmd_target, in, DUTY_W, requested duty.
- cmd_div, in, DIV_W, number of PWM periods per ramp step (0 is treated as 1).
- cmd_abort, in, 1, cancels a ramp or jump in progress.
- inc_pulse, in, 1, debounced manual +1 request.
- dec_pulse, in, 1, debounced manual -1 request.
- duty_out, out, DUTY_W, current committed duty, fed to the PWM comparator.
- duty_load, out, 1, one-cycle pulse in the cycle duty_out takes a new value.
- busy, out, 1, high in RAMP or JUMP.
- done, out, 1, one-cycle pulse when a command completes.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state = IDLE, duty_out = DUTY_RST, duty_load = 0, done = 0, busy = 0.
  - Divider count = 0, manual pending = none.
  - Reset applied mid-operation discards the command in progress.
- Commit timing:
  - All duty changes are registered: duty_out and duty_load change in the cycle after the qualifying period_end edge.
  - duty_out changes only when duty_load = 1.
- Target handling:
  - cmd_target is clamped to [DUTY_MIN, DUTY_MAX] at acceptance and latched.
  - cmd_div is latched; a latched value of 0 is stored as 1.
- IDLE state:
  - cmd_ready = 1.
  - On command accept with clamped target == duty_out: done pulses the next cycle and the state stays IDLE.
  - Otherwise go to JUMP if cmd_mode = 1, else RAMP. The divider count clears.
  - Command acceptance clears any manual pending request.
- Manual pulses (IDLE only):
  - inc_pulse sets pending = +1; dec_pulse sets pending = -1; if both arrive in the same cycle, inc wins.
  - A later pulse overwrites the pending value.
  - At the next period_end the pending step is applied, clamped to [DUTY_MIN, DUTY_MAX]. duty_load pulses only if the value actually changes. Pending then clears and done is not asserted.
  - inc_pulse and dec_pulse are ignored outside IDLE.
- RAMP state:
  - busy = 1, cmd_ready = 0.
  - Each period_end increments the divider count.
  - When the count reaches div-1 on a period_end, the count resets to 0 and duty_out moves one step toward the target.
  - When the new duty_out equals the target: done pulses in the same cycle as that duty_load, and the state returns to IDLE.
- JUMP state:
  - busy = 1.
  - On the first period_end: duty_out = target, duty_load = 1, done = 1, state returns to IDLE.
- Abort:
  - cmd_abort in RAMP or JUMP returns to IDLE next cycle; duty_out holds and there is no done.
  - If cmd_abort and a commit arrive on the same edge, abort wins and no commit occurs.
  - cmd_abort is ignored in IDLE.
- Output state: duty_out never leaves [DUTY_MIN, DUTY_MAX] after reset.
- Simultaneous period_end and cmd_valid in IDLE: the command is accepted; that period_end is not counted toward the first step.

Decomposition:
- Package pwm_pkg holds:
  - state enum: IDLE, RAMP, JUMP;
  - constants DUTY_MIN, DUTY_MAX, DUTY_RST for the 10-step PWM;
  - a clamp function.
- The top-level module instantiates one sub-module, pwm_period_div: an enable-gated divider counting period_end pulses, with a clear input and a step_tick output.
- The FSM and duty register stay in the top level.

Test Plan:
- Reset check: rst_n low for 2 cycles, then high -> duty_out = 5, duty_load = 0, busy = 0, cmd_ready = 1.
- Ramp up: ramp to 8 with div = 2, period_end every 10 cycles -> duty_out steps 6, 7, 8, one step per 2 periods. duty_load pulses 3 times; done coincides with the step to 8; busy drops the next cycle.
- Jump with clamp: jump to 15 -> target clamps to 9. duty_out = 9 the cycle after the next period_end; duty_load = 1 and done = 1 together in that cycle.
- Manual at limit: from duty 9, inc_pulse -> next period_end causes no change and no duty_load. A dec_pulse, then inc_pulse and dec_pulse together in one cycle -> pending = +1; next period_end gives no change (stays 9).
- Abort: ramp 5 -> 1 with div = 1, cmd_abort after the first step -> duty_out stays 4, no done, state IDLE, cmd_ready = 1.
- Mid-ramp reset: rst_n low during RAMP -> duty_out = 5, busy = 0. A new command of ramp to 5 -> done pulses the next cycle with no duty_load.
